// File: rtl/btn_conditioner.sv
// btn_conditioner: front end between the BASYS2 buttons/switches and the ATM core.
// Raw BTN1..BTN3 and SW are double-flop synchronized. Each button then runs its
// own IDLE/ARM/HELD/REL debounce FSM. A clean press raises a one-cycle candidate.
// Candidates are arbitrated BTN1 > BTN2 > BTN3 and gated by lock. The winner
// becomes btn_pulse, and the synchronized switches are captured into sw_q on
// that same edge.
//
// Optional build macro BTN_REPEAT_EN: a held button re-issues candidates after
// REPEAT_DELAY cycles, and then every REPEAT_PERIOD cycles.
//
// Handshake: none. btn_pulse is a fire-and-forget strobe with no ready/back-pressure.
// The core must consume it in the cycle it is high. sw_q stays stable until the
// next pulse.
//
// fsm_state exposes the per-channel FSM states for debug:
// {ch2, ch1, ch0}, 2 bits each.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_raw,
  input  logic [3:0] sw_raw,
  input  logic       lock,
  output logic [2:0] btn_pulse,
  output logic [3:0] sw_q,
  output logic [2:0] btn_level,
  output logic [5:0] fsm_state
);

  // Encoding keeps bit1 set exactly in the debounced-high states (HELD, REL).
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] HELD = 2'd2;
  localparam logic [1:0] REL  = 2'd3;

  localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEBOUNCE_CYCLES);
  // With a threshold of one sample, a single synced sample already qualifies.
  localparam bit               DEB_ONE = (DEBOUNCE_CYCLES <= 1);

  logic [2:0] btn_m, btn_s;
  logic [3:0] sw_m, sw_s;
  logic [2:0] cand;
  logic [2:0] win;

  // Two-flop synchronizers for the buttons and switches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_m <= '0;
      btn_s <= '0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= btn_raw;
      btn_s <= btn_m;
      sw_m  <= sw_raw;
      sw_s  <= sw_m;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             deb_done;
    logic             press_hit;
    logic             rep_hit;

    // The counter saturates at all-ones instead of wrapping.
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    assign deb_done  = (cnt_inc >= DEB_C);
    // A press is recognised on the same edge that moves the channel into HELD.
    assign press_hit = DEB_ONE ? ((st == IDLE) && btn_s[i])
                               : ((st == ARM) && btn_s[i] && deb_done);

    // Debounce FSM: the counter counts consecutive synced samples at the new level.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st  <= IDLE;
        cnt <= '0;
      end else begin
        case (st)
          IDLE: begin
            if (btn_s[i]) begin
              st  <= DEB_ONE ? HELD : ARM;
              cnt <= DEB_ONE ? '0 : CNT_W'(1);
            end
          end
          ARM: begin
            if (!btn_s[i]) begin
              st  <= IDLE;
              cnt <= '0;
            end else if (deb_done) begin
              st  <= HELD;
              cnt <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          HELD: begin
            if (!btn_s[i]) begin
              st  <= DEB_ONE ? IDLE : REL;
              cnt <= DEB_ONE ? '0 : CNT_W'(1);
            end
          end
          REL: begin
            if (btn_s[i]) begin
              st  <= HELD;
              cnt <= '0;
            end else if (deb_done) begin
              st  <= IDLE;
              cnt <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            st  <= IDLE;
            cnt <= '0;
          end
        endcase
      end
    end

`ifdef BTN_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_inc;
    logic [CNT_W-1:0] rep_tgt;
    logic             rep_first;

    assign rep_inc = (rep_cnt == '1) ? rep_cnt : rep_cnt + CNT_W'(1);
    assign rep_tgt = rep_first ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD);
    // A repeat fires only on an edge where the channel stays in HELD.
    assign rep_hit = (st == HELD) && btn_s[i] && (rep_inc >= rep_tgt);

    // Auto-repeat timer: restarts from the initial delay each time HELD is (re)entered.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if ((st != HELD) || !btn_s[i]) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (rep_hit) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt   <= rep_inc;
      end
    end
`else
    assign rep_hit = 1'b0;
`endif

    assign cand[i]            = press_hit | rep_hit;
    assign btn_level[i]       = st[1];
    assign fsm_state[2*i +: 2] = st;
  end

  // Fixed-priority arbiter: losers and locked candidates are simply dropped.
  always_comb begin
    win = 3'b000;
    if (!lock) begin
      if (cand[0])      win = 3'b001;
      else if (cand[1]) win = 3'b010;
      else if (cand[2]) win = 3'b100;
    end
  end

  // Register the pulse and capture the switches on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_pulse <= '0;
      sw_q      <= '0;
    end else begin
      btn_pulse <= win;
      if (win != 3'b000) sw_q <= sw_s;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed bench for btn_conditioner (DEBOUNCE_CYCLES=2).
// Cycle k means the interval following the k-th rising edge after the stimulus
// is applied. Outputs are sampled 1 ns after each rising edge.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_raw;
  logic [3:0] sw_raw;
  logic       lock;
  logic [2:0] btn_pulse;
  logic [3:0] sw_q;
  logic [2:0] btn_level;
  logic [5:0] fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle observations captured by run_seq, indexed by cycle k.
  logic [2:0] obs_p [64];
  logic [2:0] obs_l [64];
  logic [3:0] obs_s [64];

  btn_conditioner #(
    .DEBOUNCE_CYCLES(2),
    .CNT_W(20),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .sw_raw(sw_raw),
    .lock(lock),
    .btn_pulse(btn_pulse),
    .sw_q(sw_q),
    .btn_level(btn_level),
    .fsm_state(fsm_state)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  initial begin
    rst     = 1'b0;
    btn_raw = 3'b000;
    sw_raw  = 4'b0000;
    lock    = 1'b0;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Driver task: apply val in cycle 0, drop all buttons at cycle hold, drop lock
  // at cycle lock_off (0 = leave lock alone), and record outputs for cycles 1..len.
  task automatic run_seq(input logic [2:0] val, input int hold, input int lock_off,
                         input int len);
    @(posedge clk);
    #1;
    btn_raw = val;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      #1;
      obs_p[k] = btn_pulse;
      obs_l[k] = btn_level;
      obs_s[k] = sw_q;
      if (k == hold) btn_raw = 3'b000;
      if (k == lock_off) lock = 1'b0;
    end
    btn_raw = 3'b000;
  endtask

  task automatic test_reset;
    btn_raw = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({btn_pulse, sw_q, btn_level} !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: pulse=%b sw_q=%b level=%b, required all zero",
                 btn_pulse, sw_q, btn_level);
      end
    end
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (btn_pulse !== ((k == 4) ? 3'b001 : 3'b000)) begin
        n_fail++;
        $display("FAIL reset_release_pulse k=%0d: pulse=%b, required %b", k, btn_pulse,
                 (k == 4) ? 3'b001 : 3'b000);
      end
      n_checks++;
      if (btn_level !== ((k >= 4 && k < 10) ? 3'b111 : 3'b000)) begin
        n_fail++;
        $display("FAIL reset_release_level k=%0d: level=%b", k, btn_level);
      end
      if (k == 6) btn_raw = 3'b000;
    end
    n_checks++;
    if (sw_q !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_sw: sw_q=%b, required 0000", sw_q);
    end
  endtask

  task automatic test_clean_press;
    sw_raw = 4'b0101;
    idle(4);
    run_seq(3'b100, 6, 0, 12);
    for (int k = 1; k <= 12; k++) begin
      n_checks++;
      if (obs_p[k] !== ((k == 4) ? 3'b100 : 3'b000)) begin
        n_fail++;
        $display("FAIL clean_pulse k=%0d: pulse=%b", k, obs_p[k]);
      end
      n_checks++;
      if (obs_l[k] !== ((k >= 4 && k < 10) ? 3'b100 : 3'b000)) begin
        n_fail++;
        $display("FAIL clean_level k=%0d: level=%b", k, obs_l[k]);
      end
    end
    n_checks++;
    if (obs_s[4] !== 4'd5) begin
      n_fail++;
      $display("FAIL clean_sw: sw_q=%0d, required 5", obs_s[4]);
    end
  endtask

  task automatic test_glitch;
    sw_raw = 4'b1010;
    idle(3);
    run_seq(3'b010, 1, 0, 8);
    for (int k = 1; k <= 8; k++) begin
      n_checks++;
      if (obs_p[k] !== 3'b000 || obs_l[k] !== 3'b000 || obs_s[k] !== 4'b0101) begin
        n_fail++;
        $display("FAIL glitch_quiet k=%0d: pulse=%b level=%b sw_q=%b, required 000/000/0101",
                 k, obs_p[k], obs_l[k], obs_s[k]);
      end
    end
    run_seq(3'b010, 4, 0, 10);
    for (int k = 1; k <= 10; k++) begin
      n_checks++;
      if (obs_p[k] !== ((k == 4) ? 3'b010 : 3'b000)) begin
        n_fail++;
        $display("FAIL glitch_press k=%0d: pulse=%b", k, obs_p[k]);
      end
      n_checks++;
      if (obs_l[k] !== ((k >= 4 && k < 8) ? 3'b010 : 3'b000)) begin
        n_fail++;
        $display("FAIL glitch_level k=%0d: level=%b", k, obs_l[k]);
      end
    end
    n_checks++;
    if (obs_s[4] !== 4'b1010) begin
      n_fail++;
      $display("FAIL glitch_sw: sw_q=%b, required 1010", obs_s[4]);
    end
  endtask

  task automatic test_simultaneous;
    run_seq(3'b101, 8, 0, 14);
    for (int k = 1; k <= 14; k++) begin
      n_checks++;
      if (obs_p[k] !== ((k == 4) ? 3'b001 : 3'b000)) begin
        n_fail++;
        $display("FAIL simul_pulse k=%0d: pulse=%b", k, obs_p[k]);
      end
      n_checks++;
      if (obs_l[k] !== ((k >= 4 && k < 12) ? 3'b101 : 3'b000)) begin
        n_fail++;
        $display("FAIL simul_level k=%0d: level=%b", k, obs_l[k]);
      end
    end
    run_seq(3'b100, 5, 0, 10);
    for (int k = 1; k <= 10; k++) begin
      n_checks++;
      if (obs_p[k] !== ((k == 4) ? 3'b100 : 3'b000)) begin
        n_fail++;
        $display("FAIL simul_repress k=%0d: pulse=%b", k, obs_p[k]);
      end
    end
  endtask

  task automatic test_lock;
    sw_raw = 4'b1111;
    lock   = 1'b1;
    idle(3);
    run_seq(3'b010, 8, 6, 14);
    for (int k = 1; k <= 14; k++) begin
      n_checks++;
      if (obs_p[k] !== 3'b000 || obs_s[k] !== 4'b1010) begin
        n_fail++;
        $display("FAIL lock_quiet k=%0d: pulse=%b sw_q=%b, required 000/1010",
                 k, obs_p[k], obs_s[k]);
      end
      n_checks++;
      if (obs_l[k] !== ((k >= 4 && k < 12) ? 3'b010 : 3'b000)) begin
        n_fail++;
        $display("FAIL lock_level k=%0d: level=%b", k, obs_l[k]);
      end
    end
    run_seq(3'b010, 4, 0, 10);
    for (int k = 1; k <= 10; k++) begin
      n_checks++;
      if (obs_p[k] !== ((k == 4) ? 3'b010 : 3'b000)) begin
        n_fail++;
        $display("FAIL lock_repress k=%0d: pulse=%b", k, obs_p[k]);
      end
    end
    n_checks++;
    if (obs_s[4] !== 4'b1111) begin
      n_fail++;
      $display("FAIL lock_sw: sw_q=%b, required 1111", obs_s[4]);
    end
  endtask

  task automatic test_reset_mid_count;
    @(posedge clk);
    #1;
    btn_raw = 3'b001;
    idle(3);
    rst     = 1'b0;
    btn_raw = 3'b000;
    #1;
    n_checks++;
    if ({btn_pulse, sw_q, btn_level, fsm_state} !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_clear: pulse=%b sw_q=%b level=%b state=%b, required zero",
               btn_pulse, sw_q, btn_level, fsm_state);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (btn_pulse !== 3'b000 || btn_level !== 3'b000) begin
        n_fail++;
        $display("FAIL midreset_quiet k=%0d: pulse=%b level=%b, required 000/000",
                 k, btn_pulse, btn_level);
      end
    end
  endtask

`ifdef BTN_REPEAT_EN
  task automatic test_repeat;
    run_seq(3'b100, 30, 0, 40);
    for (int k = 1; k <= 40; k++) begin
      logic [2:0] e;
      e = (k == 4 || (k >= 12 && k <= 32 && (k % 4) == 0)) ? 3'b100 : 3'b000;
      n_checks++;
      if (obs_p[k] !== e) begin
        n_fail++;
        $display("FAIL repeat_pulse k=%0d: pulse=%b, required %b", k, obs_p[k], e);
      end
    end
  endtask
`endif

  initial begin
    #2;
    test_reset;
    idle(4);
    test_clean_press;
    idle(4);
    test_glitch;
    idle(4);
    test_simultaneous;
    idle(4);
    test_lock;
    idle(4);
    test_reset_mid_count;
    idle(4);
`ifdef BTN_REPEAT_EN
    test_repeat;
    idle(4);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
